// File: rtl/dma_wdata_streamer.sv
// Streams a fixed-length burst from an upstream read-latency-1 FIFO onto an AXI-style W channel.
// A 2-entry skid buffer decouples FIFO read latency from W-channel backpressure.
module dma_wdata_streamer #(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned LEN_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    srst,
  input  logic                    start_i,
  input  logic [LEN_WIDTH-1:0]    beats_i,
  input  logic [DATA_WIDTH/8-1:0] last_strb_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    fifo_rd_o,
  input  logic [DATA_WIDTH-1:0]   fifo_data_i,
  input  logic                    fifo_empty_i,
  output logic                    wvalid_o,
  input  logic                    wready_i,
  output logic [DATA_WIDTH-1:0]   wdata_o,
  output logic [DATA_WIDTH/8-1:0] wstrb_o,
  output logic                    wlast_o
);

  localparam int unsigned StrbWidth = DATA_WIDTH / 8;
  localparam logic [LEN_WIDTH:0] LenOne = (LEN_WIDTH + 1)'(1);

  typedef enum logic [1:0] {StIdle, StStream, StDone} state_e;

  state_e                 state_q;
  logic [LEN_WIDTH:0]     rd_left_q;
  logic [LEN_WIDTH:0]     wr_left_q;
  logic [DATA_WIDTH-1:0]  buf_q [2];
  logic                   rd_ptr_q;
  logic                   wr_ptr_q;
  logic [1:0]             cnt_q;
  logic                   inflight_q;
  logic [StrbWidth-1:0]   strb_q;

  logic       pop;
  logic       rd_en;
  logic [2:0] occ;

  always_comb begin
    pop   = !srst && (cnt_q != 2'd0) && wready_i;
    // Slots that will be taken once this cycle's pop and the in-flight read settle.
    occ   = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
    rd_en = !srst && (state_q == StStream) && !fifo_empty_i && (rd_left_q != '0) &&
            (occ < 3'd2);
  end

  always_comb begin
    fifo_rd_o = rd_en;
    busy_o    = !srst && (state_q == StStream);
    done_o    = !srst && (state_q == StDone);
    wvalid_o  = !srst && (cnt_q != 2'd0);
    wdata_o   = srst ? '0 : buf_q[rd_ptr_q];
    wlast_o   = wvalid_o && (wr_left_q == LenOne);
    wstrb_o   = '0;
    if (wvalid_o) wstrb_o = wlast_o ? strb_q : '1;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q    <= StIdle;
      rd_left_q  <= '0;
      wr_left_q  <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      cnt_q      <= 2'd0;
      inflight_q <= 1'b0;
      strb_q     <= '0;
      for (int i = 0; i < 2; i++) buf_q[i] <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q   <= StStream;
            rd_left_q <= {1'b0, beats_i} + LenOne;
            wr_left_q <= {1'b0, beats_i} + LenOne;
            strb_q    <= last_strb_i;
          end
        end
        StStream: if (pop && (wr_left_q == LenOne)) state_q <= StDone;
        StDone:   state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
      if (rd_en) rd_left_q <= rd_left_q - LenOne;
      if (pop) begin
        wr_left_q <= wr_left_q - LenOne;
        rd_ptr_q  <= ~rd_ptr_q;
      end
      inflight_q <= rd_en;
      if (inflight_q) begin
        buf_q[wr_ptr_q] <= fifo_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      cnt_q <= cnt_q + {1'b0, inflight_q} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_dma_wdata_streamer.sv
// Scoreboard bench: jobs push expected beats; a monitor pops and compares on each W handshake.
module tb_dma_wdata_streamer;

  localparam int DW = 512;
  localparam int LW = 8;
  localparam int SW = DW / 8;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic          last;
  } beat_t;

  logic          clk;
  logic          srst;
  logic          start_i;
  logic [LW-1:0] beats_i;
  logic [SW-1:0] last_strb_i;
  logic          busy_o;
  logic          done_o;
  logic          fifo_rd_o;
  logic [DW-1:0] fifo_data_i;
  logic          fifo_empty_i;
  logic          wvalid_o;
  logic          wready_i;
  logic [DW-1:0] wdata_o;
  logic [SW-1:0] wstrb_o;
  logic          wlast_o;

  dma_wdata_streamer #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk         (clk),
    .srst        (srst),
    .start_i     (start_i),
    .beats_i     (beats_i),
    .last_strb_i (last_strb_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .fifo_rd_o   (fifo_rd_o),
    .fifo_data_i (fifo_data_i),
    .fifo_empty_i(fifo_empty_i),
    .wvalid_o    (wvalid_o),
    .wready_i    (wready_i),
    .wdata_o     (wdata_o),
    .wstrb_o     (wstrb_o),
    .wlast_o     (wlast_o)
  );

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int seq    = 0;

  beat_t         exp_q[$];
  logic [DW-1:0] mem[$];
  logic          force_empty = 1'b0;
  logic          rd_now = 1'b0;

  int rd_cnt, beat_cnt, done_total, first_rd, first_wv, first_beat, last_beat, done_cyc;
  bit done_seen, gap_seen, stall_prev;
  logic [DW-1:0] prev_data;
  logic [SW-1:0] prev_strb;
  logic          prev_last;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string name, input logic [DW-1:0] act,
                     input logic [DW-1:0] req);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [DW-1:0] mk(input int n);
    logic [DW-1:0] w;
    for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = 32'(n * 256 + i);
    return w;
  endfunction

  task automatic chk_zero(input string name);
    logic ok;
    ok = ({busy_o, done_o, fifo_rd_o, wvalid_o, wlast_o} == 5'd0) && (wstrb_o == '0) &&
         (wdata_o == '0);
    chk(ok, name, DW'({busy_o, done_o, fifo_rd_o, wvalid_o, wlast_o}), '0);
  endtask

  // Upstream FIFO model: data appears the cycle after the read is sampled.
  always @(posedge clk) begin
    cyc++;
    if (rd_now && mem.size() > 0) fifo_data_i <= mem.pop_front();
  end

  always @(negedge clk) begin
    #1 fifo_empty_i = force_empty || (mem.size() == 0);
  end

  always @(negedge clk) begin
    beat_t e;
    #2;
    if (fifo_rd_o) begin
      rd_cnt++;
      chk(!fifo_empty_i, "rd_while_empty", DW'(fifo_empty_i), '0);
      if (first_rd < 0) first_rd = cyc;
    end
    rd_now = fifo_rd_o;
    if (wvalid_o && first_wv < 0) first_wv = cyc;
    if (busy_o && !wvalid_o && first_wv >= 0) gap_seen = 1'b1;
    if (stall_prev) begin
      chk(wvalid_o && wdata_o == prev_data && wstrb_o == prev_strb && wlast_o == prev_last,
          "stall_stable", wdata_o, prev_data);
    end
    stall_prev = wvalid_o && !wready_i;
    prev_data  = wdata_o;
    prev_strb  = wstrb_o;
    prev_last  = wlast_o;
    if (wvalid_o && wready_i) begin
      beat_cnt++;
      if (first_beat < 0) first_beat = cyc;
      last_beat = cyc;
      if (exp_q.size() == 0) begin
        chk(1'b0, "unexpected_beat", wdata_o, '0);
      end else begin
        e = exp_q.pop_front();
        chk(wdata_o == e.data, "wdata", wdata_o, e.data);
        chk(wstrb_o == e.strb, "wstrb", DW'(wstrb_o), DW'(e.strb));
        chk(wlast_o == e.last, "wlast", DW'(wlast_o), DW'(e.last));
      end
    end
    if (done_o) begin
      done_total++;
      done_seen = 1'b1;
      done_cyc  = cyc;
    end
  end

  task automatic setup_job(input int beats, input logic [SW-1:0] strb);
    beat_t b;
    rd_cnt = 0; beat_cnt = 0; done_seen = 0; gap_seen = 0;
    first_rd = -1; first_wv = -1; first_beat = -1; last_beat = -1; done_cyc = -1;
    for (int i = 0; i <= beats; i++) begin
      b.data = mk(seq);
      b.strb = (i == beats) ? strb : '1;
      b.last = (i == beats);
      mem.push_back(b.data);
      exp_q.push_back(b);
      seq++;
    end
  endtask

  // mode 1 toggles wready; pulse_at fires a stray start; empty_* forces FIFO empty mid-burst.
  task automatic run_job(input int beats, input logic [SW-1:0] strb, input bit mode,
                         input int pulse_at, input int empty_from, input int empty_len,
                         input bit lat);
    int start_cyc;
    setup_job(beats, strb);
    @(negedge clk);
    start_i = 1'b1; beats_i = LW'(beats); last_strb_i = strb; wready_i = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start_i = 1'b0;
    for (int n = 0; n < beats * 3 + 40; n++) begin
      if (done_seen) break;
      wready_i    = mode ? n[0] : 1'b1;
      force_empty = (n >= empty_from) && (n < empty_from + empty_len);
      start_i     = (n == pulse_at);
      if (n == pulse_at) beats_i = LW'(3);
      @(negedge clk);
    end
    start_i = 1'b0; force_empty = 1'b0; wready_i = 1'b1;
    chk(done_seen, "done_seen", DW'(done_seen), DW'(1));
    chk(rd_cnt == beats + 1, "read_count", DW'(rd_cnt), DW'(beats + 1));
    chk(beat_cnt == beats + 1, "beat_count", DW'(beat_cnt), DW'(beats + 1));
    chk(exp_q.size() == 0, "exp_drained", DW'(exp_q.size()), '0);
    chk(done_cyc == last_beat + 1, "done_latency", DW'(done_cyc), DW'(last_beat + 1));
    if (lat) begin
      chk(first_rd == start_cyc + 1, "first_rd", DW'(first_rd), DW'(start_cyc + 1));
      chk(first_wv == first_rd + 2, "first_wvalid", DW'(first_wv), DW'(first_rd + 2));
      chk(last_beat - first_beat == beats, "throughput", DW'(last_beat - first_beat),
          DW'(beats));
      chk(!gap_seen, "no_gap", DW'(gap_seen), '0);
    end
    if (empty_len > 0) chk(gap_seen, "gap_on_empty", DW'(gap_seen), DW'(1));
    #3 chk(!busy_o && !done_o && !wvalid_o, "idle_after", DW'({busy_o, done_o, wvalid_o}), '0);
  endtask

  initial begin
    int d0;
    srst = 1'b1; start_i = 1'b0; beats_i = '0; last_strb_i = '0; wready_i = 1'b1;
    fifo_data_i = '0; fifo_empty_i = 1'b1; done_total = 0; stall_prev = 1'b0;
    repeat (3) @(negedge clk);
    #3 chk_zero("reset_during");
    @(negedge clk);
    srst = 1'b0;
    #3 chk_zero("reset_after");

    run_job(3, SW'(64'hF0F0), 1'b0, -1, 1000, 0, 1'b1);
    run_job(0, SW'(64'h000F), 1'b0, -1, 1000, 0, 1'b1);
    run_job(7, SW'(64'h00FF), 1'b1, -1, 1000, 0, 1'b0);
    run_job(7, SW'(64'h0F0F), 1'b0, -1, 3, 5, 1'b0);
    run_job(255, SW'(64'hABCD), 1'b0, 40, 1000, 0, 1'b0);

    // Abort an 8-beat job after its second beat.
    setup_job(7, SW'(64'h1234));
    @(negedge clk);
    start_i = 1'b1; beats_i = LW'(7); last_strb_i = SW'(64'h1234);
    @(negedge clk);
    start_i = 1'b0;
    for (int n = 0; n < 40 && beat_cnt < 2; n++) @(negedge clk);
    chk(beat_cnt == 2, "abort_point", DW'(beat_cnt), DW'(2));
    d0 = done_total;
    srst = 1'b1;
    mem.delete();
    exp_q.delete();
    #3 chk_zero("abort_during");
    @(negedge clk);
    srst = 1'b0;
    #3 chk_zero("abort_after");
    repeat (5) @(negedge clk);
    chk(done_total == d0, "no_done_on_abort", DW'(done_total), DW'(d0));
    chk(!fifo_rd_o && !wvalid_o, "quiet_after_abort", DW'({fifo_rd_o, wvalid_o}), '0);

    run_job(7, SW'(64'h5555), 1'b0, -1, 1000, 0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
